// File: rtl/i2s_tx_48k_pkg.sv
// Shared types and helpers for the i2s_tx_48k output stage.
package i2s_tx_48k_pkg;

  localparam int I2S_BITS_PER_FRAME = 64;
  localparam int I2S_MAX_W          = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  // Widest legal sample. A W-bit sample is carried in its low W bits.
  typedef logic signed [I2S_MAX_W-1:0] sample_t;

  // Moves a W-bit sample held in the low bits of sample_t so that its MSB
  // lands on bit 31 of a 32-bit slot, with zero padding below the LSB.
  function automatic logic [31:0] left_align(input sample_t s, input int unsigned width);
    logic [31:0] slot;
    slot = {s, 8'h00};
    return slot << (I2S_MAX_W - width);
  endfunction

  // Serial bit for bit_cnt = n. Slot bit k=(n-1) mod 32 maps to slot[31-k],
  // so n=1 gives the MSB and n=0 gives the final (always zero) pad bit.
  function automatic logic slot_bit(input logic [31:0] slot, input logic [5:0] n);
    logic [4:0] k;
    k = n[4:0] - 5'd1;
    return slot[~k];
  endfunction

endpackage

// File: rtl/i2s_tx_48k_if.sv
// Sample input, flag control and I2S output bundle for i2s_tx_48k.
interface i2s_tx_48k_if #(
  parameter int W     = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                 en;
  logic signed [W-1:0]  in;
  logic                 clr;
  logic                 bclk;
  logic                 lrck;
  logic                 sdat;
  logic                 ovf;
  logic                 udf;
  logic [LW-1:0]        level;

  // Sample source / flag owner side.
  modport master (
    output en, in, clr,
    input  bclk, lrck, sdat, ovf, udf, level
  );

  // Transmitter side.
  modport slave (
    input  en, in, clr,
    output bclk, lrck, sdat, ovf, udf, level
  );
endinterface

// File: rtl/i2s_tx_48k_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A write to a full FIFO is
// accepted only when a read in the same cycle frees a slot.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_ok, rd_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Accept/pop decisions and next pointer/occupancy values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_ok    = rd && !empty;
    wr_ok    = wr && (!full || rd_ok);
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d  = level_q + LW'(wr_ok) - LW'(rd_ok);
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers alone define which words are valid.
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/i2s_tx_48k.sv
// Mono-to-I2S transmitter locked to 48 kHz frames (64 bclk) from a
// 28.224 MHz clock. Each sample is sent on both left and right slots.
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: when defined an underrun
// repeats the previous word; otherwise an underrun sends zeros.
module i2s_tx_48k
  import i2s_tx_48k_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int PRIME = 2,
  parameter int NUM   = 32,
  parameter int DEN   = 147
) (
  input  logic         clk,
  input  logic         rst_n,
  i2s_tx_48k_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  i2s_state_t    state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          sdat_q, sdat_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          started_q, started_d;
  logic [W-1:0]  word_q, word_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [8:0]    acc_sum;
  logic          half_edge;
  logic          udf_set;
  logic          ovf_set;
  logic          fifo_rd;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (bus.en),
    .wr_data (bus.in),
    .rd      (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Start-up FSM, fractional edge generator, bit counter and serializer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    sdat_d    = sdat_q;
    bit_cnt_d = bit_cnt_q;
    started_d = started_q;
    word_d    = word_q;
    fifo_rd   = 1'b0;
    udf_set   = 1'b0;
    half_edge = 1'b0;
    acc_sum   = {1'b0, acc_q} + 9'(NUM);

    case (state_q)
      IDLE: begin
        if (fifo_level >= LW'(PRIME)) state_d = RUN;
      end
      RUN: begin
        if (acc_sum >= 9'(DEN)) begin
          acc_d     = 8'(acc_sum - 9'(DEN));
          half_edge = 1'b1;
        end else begin
          acc_d = acc_sum[7:0];
        end
        if (half_edge) begin
          bclk_d = !bclk_q;
          if (bclk_q) begin
            // Falling edge: the very first one after RUN entry is a frame start.
            started_d = 1'b1;
            bit_cnt_d = started_q ? bit_cnt_q + 6'd1 : 6'd0;
            if (bit_cnt_d == 6'd0) begin
              fifo_rd = 1'b1;
              if (fifo_empty) begin
                udf_set = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                word_d  = word_q;
`else
                word_d  = '0;
`endif
              end else begin
                word_d = fifo_rd_data;
              end
            end
            lrck_d = bit_cnt_d[5];
            sdat_d = slot_bit(left_align(sample_t'(word_d), W), bit_cnt_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO only takes a write when this cycle's frame-start pop frees a slot.
    ovf_set = bus.en && fifo_full && !fifo_rd;
    ovf_d   = ovf_set ? 1'b1 : (bus.clr ? 1'b0 : ovf_q);
    udf_d   = udf_set ? 1'b1 : (bus.clr ? 1'b0 : udf_q);
  end

  // State registers; reset returns everything to IDLE values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdat_q    <= 1'b0;
      bit_cnt_q <= '0;
      started_q <= 1'b0;
      word_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdat_q    <= sdat_d;
      bit_cnt_q <= bit_cnt_d;
      started_q <= started_d;
      word_q    <= word_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign bus.bclk  = bclk_q;
  assign bus.lrck  = lrck_q;
  assign bus.sdat  = sdat_q;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
  assign bus.level = fifo_level;

endmodule

// File: tb/tb_i2s_tx_48k.sv
// Scoreboard bench for i2s_tx_48k: stimulus queues expected 32-bit slots,
// a monitor rebuilds each frame from bclk/lrck/sdat and compares.
module tb_i2s_tx_48k;
  localparam int W         = 16;
  localparam int DEPTH     = 4;
  localparam int PRIME     = 2;
  localparam int NUM       = 32;
  localparam int DEN       = 147;
  localparam int FRAME_CLK = 588;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_48k_if #(.W(W), .DEPTH(DEPTH)) bus ();

  i2s_tx_48k #(
    .W(W), .DEPTH(DEPTH), .PRIME(PRIME), .NUM(NUM), .DEN(DEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int frames_checked = 0;

  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic wait_lrck(input logic rising, input int budget, input string name);
    logic prev;
    bit   ok;
    prev = bus.lrck;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.lrck !== prev && bus.lrck === rising) begin
        ok = 1'b1;
        break;
      end
      prev = bus.lrck;
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_bclk(input logic rising, input int count, input int budget, input string name);
    logic prev;
    int   seen;
    prev = bus.bclk;
    seen = 0;
    for (int i = 0; i < budget && seen < count; i++) begin
      @(negedge clk);
      if (prev === !rising && bus.bclk === rising) seen++;
      prev = bus.bclk;
    end
    if (seen < count) timeout(name);
  endtask

  task automatic push_sample(input logic [W-1:0] value, input logic [31:0] exp_slot);
    @(negedge clk);
    bus.en = 1'b1;
    bus.in = value;
    exp_q.push_back(exp_slot);
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_bclk  = 1'b0;
  logic        m_started  = 1'b0;
  logic [5:0]  m_n        = '0;
  bit          fs_seen    = 1'b0;
  bit          have_frame = 1'b0;
  int          clk_cnt    = 0;
  int          last_fs    = 0;
  int          toggles    = 0;
  int          lrck_err   = 0;
  logic [31:0] cur_exp    = '0;
  logic [31:0] last_slot  = '0;
  logic [31:0] left_bits  = '0;
  logic [30:0] right_bits = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bclk  = 1'b0;
        m_started  = 1'b0;
        fs_seen    = 1'b0;
        have_frame = 1'b0;
        toggles    = 0;
        clk_cnt    = 0;
        last_slot  = '0;
      end else begin
        clk_cnt++;
        if (bus.bclk !== prev_bclk) toggles++;
        if (prev_bclk === 1'b1 && bus.bclk === 1'b0) begin
          if (!m_started) begin
            m_started = 1'b1;
            m_n       = 6'd0;
          end else begin
            m_n = m_n + 6'd1;
          end
          if (m_n == 6'd0) begin
            if (fs_seen) begin
              check("frame_period_clk", 32'(clk_cnt - last_fs), 32'(FRAME_CLK));
              check("bclk_edges_per_frame", 32'(toggles), 32'd128);
            end
            fs_seen  = 1'b1;
            last_fs  = clk_cnt;
            toggles  = 0;
            lrck_err = 0;
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
              cur_exp = last_slot;
`else
              cur_exp = 32'h0000_0000;
`endif
            end
            last_slot  = cur_exp;
            have_frame = 1'b1;
          end else if (m_n <= 6'd32) begin
            left_bits[32 - int'(m_n)] = bus.sdat;
          end else begin
            right_bits[63 - int'(m_n)] = bus.sdat;
          end
          if (bus.lrck !== m_n[5]) lrck_err++;
          if (m_n == 6'd63 && have_frame) begin
            check("left_slot", left_bits, cur_exp);
            check("right_slot", 32'(right_bits), 32'(cur_exp[31:1]));
            check("lrck_per_bit", 32'(lrck_err), 32'd0);
            frames_checked++;
          end
        end
        prev_bclk = bus.bclk;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ovf_vals [6];
  logic [31:0]  ovf_exp  [4];

  initial begin
    int hi_cnt;
    bit seen_udf;
    ovf_vals = '{16'hFFFE, 16'h0001, 16'h8000, 16'h1234, 16'h5555, 16'hAAAA};
    ovf_exp  = '{32'hFFFE_0000, 32'h0001_0000, 32'h8000_0000, 32'h1234_0000};
    bus.en  = 1'b0;
    bus.in  = '0;
    bus.clr = 1'b0;

    // Reset held 10 clk while en pulses.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.en = (i % 2 == 0);
      bus.in = 16'h7777;
    end
    check("rst_bclk",  32'(bus.bclk),  32'd0);
    check("rst_lrck",  32'(bus.lrck),  32'd0);
    check("rst_sdat",  32'(bus.sdat),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_udf",   32'(bus.udf),   32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;

    // Overflow: six back-to-back writes before the first frame; only four fit.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.in = ovf_vals[i];
      if (i < 4) exp_q.push_back(ovf_exp[i]);
    end
    @(negedge clk);
    bus.en = 1'b0;
    check("level_full", 32'(bus.level), 32'd4);
    check("ovf_set",    32'(bus.ovf),   32'd1);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // Underrun: no more writes; the four words drain, then udf rises.
    seen_udf = 1'b0;
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (bus.udf === 1'b1) begin
        seen_udf = 1'b1;
        break;
      end
    end
    if (!seen_udf) timeout("udf_wait");
    check("udf_set",       32'(bus.udf),   32'd1);
    check("level_drained", 32'(bus.level), 32'd0);

    // clr mid-frame, away from any frame start.
    wait_lrck(1'b1, 2 * FRAME_CLK, "clr_sync");
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("udf_clr", 32'(bus.udf), 32'd0);

    // Steady ramp: one write per frame, placed mid-frame.
    for (int i = 1; i <= 5; i++) begin
      wait_lrck(1'b1, 2 * FRAME_CLK, "ramp_sync");
      push_sample(W'(i), 32'(i) << 16);
    end

    // Async reset at bit_cnt=20 of an underrun frame with one word buffered.
    wait_lrck(1'b0, 2 * FRAME_CLK, "rst_sync_a");
    wait_lrck(1'b0, 2 * FRAME_CLK, "rst_sync_b");
    wait_bclk(1'b0, 10, 200, "rst_n10");
    @(negedge clk);
    bus.en = 1'b1;
    bus.in = 16'h4321;
    @(negedge clk);
    bus.en = 1'b0;
    wait_bclk(1'b0, 10, 200, "rst_n20");
    wait_bclk(1'b1, 1, 20, "rst_bclk_hi");
    check("pre_rst_level", 32'(bus.level), 32'd1);
    check("pre_rst_udf",   32'(bus.udf),   32'd1);
    check("pre_rst_bclk",  32'(bus.bclk),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_bclk",  32'(bus.bclk),  32'd0);
    check("async_lrck",  32'(bus.lrck),  32'd0);
    check("async_sdat",  32'(bus.sdat),  32'd0);
    check("async_udf",   32'(bus.udf),   32'd0);
    check("async_level", 32'(bus.level), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;

    // Restart: one sample is below PRIME, so no bit clock yet.
    push_sample(16'h0BAD, 32'h0BAD_0000);
    hi_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.bclk !== 1'b0) hi_cnt++;
    end
    check("idle_below_prime", 32'(hi_cnt), 32'd0);
    check("restart_level",    32'(bus.level), 32'd1);
    push_sample(16'h7FFF, 32'h7FFF_0000);
    for (int i = 0; i < 3; i++) wait_lrck(1'b0, 2 * FRAME_CLK, "restart_frames");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frames_seen_min", 32'(frames_checked >= 12), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
